// File: rtl/cmmdc_pkg.sv
// Shared definitions for the parametrised GCD engine: FSM states, algorithm
// select encoding and the width of the common power-of-two counter k.
package cmmdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_SUB   = 1'b0;
  localparam logic MODE_STEIN = 1'b1;

  // k counts shared factors of two, so it never exceeds WIDTH
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/cmmdc_step.sv
// One reduction step of the GCD loop: subtractive Euclid or binary Stein,
// applied only while neither operand is zero and X != Y.
module cmmdc_step
  import cmmdc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  input  logic             mode,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] y_next,
  output logic [KW-1:0]    k_next
);

  logic [WIDTH-1:0] diff_xy;
  logic [WIDTH-1:0] diff_yx;
  logic             x_gt_y;

  assign diff_xy = x - y;
  assign diff_yx = y - x;
  assign x_gt_y  = (x > y);

  always_comb begin
    x_next = x;
    y_next = y;
    k_next = k;
    if (mode == MODE_SUB) begin
      if (x_gt_y) x_next = diff_xy;
      else        y_next = diff_yx;
    end else begin
      // priority: both even, X even, Y even, both odd
      case ({x[0], y[0]})
        2'b00: begin
          x_next = x >> 1;
          y_next = y >> 1;
          k_next = k + 1'b1;
        end
        2'b01:   x_next = x >> 1;
        2'b10:   y_next = y >> 1;
        default: begin
          if (x_gt_y) x_next = diff_xy >> 1;
          else        y_next = diff_yx >> 1;
        end
      endcase
    end
  end

endmodule

// File: rtl/cmmdc_param.sv
// Parametrised GCD engine with start/busy/ack handshake, zero-operand error
// flag and a saturating count of RUN cycles for the last operation.
module cmmdc_param
  import cmmdc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] rez,
  output logic             ack,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  localparam int KW = k_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [KW-1:0]    k_reg, k_next;
  logic             mode_reg, mode_next;
  logic [WIDTH-1:0] rez_reg, rez_next;
  logic             ack_reg, ack_next;
  logic             busy_reg, busy_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;

  logic [WIDTH-1:0] step_x;
  logic [WIDTH-1:0] step_y;
  logic [KW-1:0]    step_k;
  logic [CNT_W-1:0] cycles_inc;

  cmmdc_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .x      (x_reg),
    .y      (y_reg),
    .k      (k_reg),
    .mode   (mode_reg),
    .x_next (step_x),
    .y_next (step_y),
    .k_next (step_k)
  );

  assign cycles_inc = (&cycles_reg) ? cycles_reg : cycles_reg + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      k_reg      <= '0;
      mode_reg   <= MODE_SUB;
      rez_reg    <= '0;
      ack_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      k_reg      <= k_next;
      mode_reg   <= mode_next;
      rez_reg    <= rez_next;
      ack_reg    <= ack_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
      cycles_reg <= cycles_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    k_next      = k_reg;
    mode_next   = mode_reg;
    rez_next    = rez_reg;
    ack_next    = ack_reg;
    busy_next   = busy_reg;
    err_next    = err_reg;
    cycles_next = cycles_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next      = A;
          y_next      = B;
          k_next      = '0;
          mode_next   = mode;
          rez_next    = '0;
          ack_next    = 1'b0;
          err_next    = 1'b0;
          cycles_next = '0;
          busy_next   = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        cycles_next = cycles_inc;
        if (x_reg == '0 || y_reg == '0) begin
          rez_next   = x_reg | y_reg;
          err_next   = (x_reg == '0) && (y_reg == '0);
          ack_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (x_reg == y_reg) begin
          // result never exceeds min(A,B), so restoring 2^k cannot overflow
          rez_next   = x_reg << k_reg;
          ack_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          x_next = step_x;
          y_next = step_y;
          k_next = step_k;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rez    = rez_reg;
  assign ack    = ack_reg;
  assign busy   = busy_reg;
  assign err    = err_reg;
  assign cycles = cycles_reg;

endmodule
